// File: rtl/seven_seg_scan_capture_if.sv
// Multiplexed seven-segment display bus: active-low segment pattern plus active-low anode enables.
interface seven_seg_scan_capture_if;
   logic [6:0] seg;
   logic [5:0] an;

   modport master (output seg, output an);
   modport slave  (input  seg, input  an);
endinterface

// File: rtl/seven_seg_scan_capture.sv
// Loopback monitor that rebuilds a six-digit frame from a multiplexed active-low
// seven-segment bus, flagging illegal patterns, anode conflicts and a stalled scan.
module seven_seg_scan_capture #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned TIMEOUT       = 1_500_000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   seven_seg_scan_capture_if.slave bus,
   output logic [3:0]              sec_ones,
   output logic [3:0]              sec_tens,
   output logic [3:0]              min_ones,
   output logic [3:0]              min_tens,
   output logic [3:0]              hrs_ones,
   output logic [3:0]              hrs_tens,
   output logic [5:0]              digit_ok,
   output logic                    frame_done,
   output logic                    seg_err,
   output logic                    an_err,
   output logic                    stale
);
   localparam int unsigned SEG_W = 7;
   localparam int unsigned AN_W  = 6;
   localparam int unsigned DIG_W = 4;
   localparam int unsigned SW    = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned TW    = $clog2(TIMEOUT + 1);

   logic [AN_W-1:0]            an_s1, an_s2, an_p;
   logic [SEG_W-1:0]           seg_s1, seg_s2, seg_p;
   logic [SW-1:0]              settle_cnt;
   logic                       captured;
   logic [TW-1:0]              tmo_cnt;
   logic [AN_W-1:0]            seen;
   logic [AN_W-1:0][DIG_W-1:0] cap;
   logic [AN_W-1:0]            cap_ok;

   logic                       stable, one_hot, multi, settle_hit, do_cap, tmo_hit, frame_fire;
   logic [AN_W-1:0]            an_low, seen_next;
   logic [DIG_W-1:0]           dec_val;
   logic                       dec_legal;

   // Segment pattern back to a hex value; anything off-table decodes as F/illegal.
   always_comb begin
      dec_val   = 4'hF;
      dec_legal = 1'b1;
      case (seg_s2)
         7'b1000000: dec_val = 4'h0;
         7'b1111001: dec_val = 4'h1;
         7'b0100100: dec_val = 4'h2;
         7'b0110000: dec_val = 4'h3;
         7'b0011001: dec_val = 4'h4;
         7'b0010010: dec_val = 4'h5;
         7'b0000010: dec_val = 4'h6;
         7'b1111000: dec_val = 4'h7;
         7'b0000000: dec_val = 4'h8;
         7'b0011000: dec_val = 4'h9;
         7'b0001000: dec_val = 4'hA;
         7'b0000011: dec_val = 4'hB;
         7'b1000110: dec_val = 4'hC;
         7'b0100001: dec_val = 4'hD;
         7'b0000110: dec_val = 4'hE;
         7'b0001110: dec_val = 4'hF;
         default: begin
            dec_val   = 4'hF;
            dec_legal = 1'b0;
         end
      endcase
   end

   // Dwell qualification, capture/timeout arbitration and next seen mask.
   always_comb begin
      stable     = ({an_s2, seg_s2} == {an_p, seg_p});
      an_low     = ~an_s2;
      one_hot    = (an_low != '0) && ((an_low & (an_low - AN_W'(1))) == '0);
      multi      = (an_low != '0) && !one_hot;
      settle_hit = stable && !captured && (settle_cnt == SW'(SETTLE_CYCLES - 1));
      do_cap     = settle_hit && one_hot;
      tmo_hit    = !do_cap && (tmo_cnt == TW'(TIMEOUT - 1));
      frame_fire = (seen == '1);
      seen_next  = (frame_fire || tmo_hit) ? '0 : seen;
      if (do_cap) begin
         seen_next = seen_next | an_low;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an_s1      <= '1;
         an_s2      <= '1;
         an_p       <= '1;
         seg_s1     <= '1;
         seg_s2     <= '1;
         seg_p      <= '1;
         settle_cnt <= '0;
         captured   <= 1'b0;
         tmo_cnt    <= '0;
         seen       <= '0;
         cap        <= '0;
         cap_ok     <= '0;
         sec_ones   <= '0;
         sec_tens   <= '0;
         min_ones   <= '0;
         min_tens   <= '0;
         hrs_ones   <= '0;
         hrs_tens   <= '0;
         digit_ok   <= '0;
         frame_done <= 1'b0;
         seg_err    <= 1'b0;
         an_err     <= 1'b0;
         stale      <= 1'b1;
      end else begin
         an_s1  <= bus.an;
         an_s2  <= an_s1;
         an_p   <= an_s2;
         seg_s1 <= bus.seg;
         seg_s2 <= seg_s1;
         seg_p  <= seg_s2;

         if (!stable) begin
            settle_cnt <= '0;
            captured   <= 1'b0;
         end else begin
            if (settle_cnt != SW'(SETTLE_CYCLES)) begin
               settle_cnt <= settle_cnt + SW'(1);
            end
            if (settle_hit) begin
               captured <= 1'b1;
            end
         end

         seen       <= seen_next;
         seg_err    <= do_cap && !dec_legal;
         an_err     <= settle_hit && multi;
         frame_done <= frame_fire;

         for (int i = 0; i < int'(AN_W); i++) begin
            if (do_cap && an_low[i]) begin
               cap[i]    <= dec_val;
               cap_ok[i] <= dec_legal;
            end
         end

         // A capture always restarts the stall timer, even on the limit cycle.
         if (do_cap) begin
            tmo_cnt <= '0;
         end else if (tmo_cnt != TW'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end

         if (frame_fire) begin
            sec_ones <= cap[0];
            sec_tens <= cap[1];
            min_ones <= cap[2];
            min_tens <= cap[3];
            hrs_ones <= cap[4];
            hrs_tens <= cap[5];
            digit_ok <= cap_ok;
         end

         if (tmo_hit) begin
            stale <= 1'b1;
         end else if (frame_fire) begin
            stale <= 1'b0;
         end
      end
   end
endmodule
